// File: rtl/legv8_pkg.sv
// LEGv8 decode constants and the control bundle
// shared by the decode stage and its decoder.
package legv8_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [4:0] XZR = 5'd31;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ORR  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       alusrc;
    logic       cbz;
    logic       b_uncond;
    logic       illegal;
    logic [3:0] aluctl;
  } ctrl_t;

endpackage

// File: rtl/id_stage_if.sv
// Fetch-side handshake and ID/EX register outputs
// of the decode stage.
interface id_stage_if #(
  parameter int DW = 64,
  parameter int AW = 5
);
  logic          if_valid;
  logic [31:0]   if_instr;
  logic [DW-1:0] if_pc;
  logic          stall;
  logic          flush;
  logic          ex_valid;
  logic [DW-1:0] ex_pc;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic [DW-1:0] ex_imm;
  logic [AW-1:0] ex_wa;
  logic          ex_regwrite;
  logic          ex_memread;
  logic          ex_memwrite;
  logic          ex_alusrc;
  logic          ex_cbz;
  logic          ex_b_uncond;
  logic [3:0]    ex_aluctl;
  logic          ex_illegal;

  modport master (
    output if_valid, if_instr, if_pc, flush,
    input  stall, ex_valid, ex_pc, ex_a, ex_b,
    input  ex_imm, ex_wa, ex_regwrite,
    input  ex_memread, ex_memwrite, ex_alusrc,
    input  ex_cbz, ex_b_uncond, ex_aluctl,
    input  ex_illegal
  );

  modport slave (
    input  if_valid, if_instr, if_pc, flush,
    output stall, ex_valid, ex_pc, ex_a, ex_b,
    output ex_imm, ex_wa, ex_regwrite,
    output ex_memread, ex_memwrite, ex_alusrc,
    output ex_cbz, ex_b_uncond, ex_aluctl,
    output ex_illegal
  );
endinterface

// File: rtl/legv8_decoder.sv
// Combinational LEGv8 decoder: control bundle,
// register fields, immediate and source usage.
module legv8_decoder
  import legv8_pkg::*;
#(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic [31:0]   instr,
  output ctrl_t         ctrl,
  output logic [AW-1:0] ra1,
  output logic [AW-1:0] ra2,
  output logic [AW-1:0] wa,
  output logic [DW-1:0] imm,
  output logic          uses_ra1,
  output logic          uses_ra2
);

  logic [10:0] op;
  assign op = instr[31:21];

  always_comb begin
    ctrl     = '0;
    ra1      = instr[9:5];
    ra2      = instr[20:16];
    wa       = instr[4:0];
    imm      = '0;
    uses_ra1 = 1'b0;
    uses_ra2 = 1'b0;
    unique case (1'b1)
      op == OP_ADD: begin
        ctrl.regwrite = 1'b1;
        ctrl.aluctl   = ALU_ADD;
        uses_ra1      = 1'b1;
        uses_ra2      = 1'b1;
      end
      op == OP_SUB: begin
        ctrl.regwrite = 1'b1;
        ctrl.aluctl   = ALU_SUB;
        uses_ra1      = 1'b1;
        uses_ra2      = 1'b1;
      end
      op == OP_AND: begin
        ctrl.regwrite = 1'b1;
        ctrl.aluctl   = ALU_AND;
        uses_ra1      = 1'b1;
        uses_ra2      = 1'b1;
      end
      op == OP_ORR: begin
        ctrl.regwrite = 1'b1;
        ctrl.aluctl   = ALU_ORR;
        uses_ra1      = 1'b1;
        uses_ra2      = 1'b1;
      end
      op == OP_LDUR: begin
        imm           = {{(DW-9){instr[20]}}, instr[20:12]};
        ctrl.alusrc   = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.aluctl   = ALU_ADD;
        uses_ra1      = 1'b1;
      end
      op == OP_STUR: begin
        ra2           = instr[4:0];
        imm           = {{(DW-9){instr[20]}}, instr[20:12]};
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.aluctl   = ALU_ADD;
        uses_ra1      = 1'b1;
        uses_ra2      = 1'b1;
      end
      instr[31:24] == OP_CBZ: begin
        ra2         = instr[4:0];
        imm         = {{(DW-19){instr[23]}}, instr[23:5]};
        ctrl.cbz    = 1'b1;
        ctrl.aluctl = ALU_PASS;
        uses_ra2    = 1'b1;
      end
      instr[31:26] == OP_B: begin
        imm           = {{(DW-26){instr[25]}}, instr[25:0]};
        ctrl.b_uncond = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// LEGv8 decode stage: IF/ID and ID/EX registers,
// writeback bypass, load-use stall and flush.
module id_stage
  import legv8_pkg::*;
#(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  id_stage_if.slave     bus,
  output logic [AW-1:0] ra1,
  output logic [AW-1:0] ra2,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_wa,
  input  logic [DW-1:0] wb_wd
);

  localparam logic [AW-1:0] ZR = AW'(XZR);

  logic          ifid_valid_q, ifid_valid_d;
  logic [31:0]   ifid_instr_q, ifid_instr_d;
  logic [DW-1:0] ifid_pc_q, ifid_pc_d;

  logic          ex_valid_q, ex_valid_d;
  logic [DW-1:0] ex_pc_q, ex_pc_d;
  logic [DW-1:0] ex_a_q, ex_a_d;
  logic [DW-1:0] ex_b_q, ex_b_d;
  logic [DW-1:0] ex_imm_q, ex_imm_d;
  logic [AW-1:0] ex_wa_q, ex_wa_d;
  ctrl_t         ex_ctrl_q, ex_ctrl_d;

  ctrl_t         dec_ctrl;
  logic [AW-1:0] dec_ra1, dec_ra2, dec_wa;
  logic [DW-1:0] dec_imm;
  logic          dec_use1, dec_use2;
  logic [DW-1:0] opnd_a, opnd_b;
  logic          src_hit, stall;

  legv8_decoder #(.DW(DW), .AW(AW)) u_dec (
    .instr    (ifid_instr_q),
    .ctrl     (dec_ctrl),
    .ra1      (dec_ra1),
    .ra2      (dec_ra2),
    .wa       (dec_wa),
    .imm      (dec_imm),
    .uses_ra1 (dec_use1),
    .uses_ra2 (dec_use2)
  );

  assign ra1 = dec_ra1;
  assign ra2 = dec_ra2;

  // The RF write lands at the same edge we capture, so bypass it
  always_comb begin
    opnd_a = rd1;
    opnd_b = rd2;
    if (dec_ra1 == ZR)
      opnd_a = '0;
    else if (wb_we && wb_wa == dec_ra1)
      opnd_a = wb_wd;
    if (dec_ra2 == ZR)
      opnd_b = '0;
    else if (wb_we && wb_wa == dec_ra2)
      opnd_b = wb_wd;
  end

  always_comb begin
    src_hit = (dec_use1 && dec_ra1 == ex_wa_q)
           || (dec_use2 && dec_ra2 == ex_wa_q);
    stall = ex_valid_q && ex_ctrl_q.memread
         && (ex_wa_q != ZR) && src_hit
         && ifid_valid_q && !bus.flush;
  end

  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    if (bus.flush) begin
      ifid_valid_d = 1'b0;
    end else if (!stall) begin
      ifid_valid_d = bus.if_valid;
      ifid_instr_d = bus.if_instr;
      ifid_pc_d    = bus.if_pc;
    end
  end

  always_comb begin
    ex_valid_d = 1'b0;
    ex_pc_d    = '0;
    ex_a_d     = '0;
    ex_b_d     = '0;
    ex_imm_d   = '0;
    ex_wa_d    = '0;
    ex_ctrl_d  = '0;
    if (!(bus.flush || stall || !ifid_valid_q)) begin
      ex_valid_d = 1'b1;
      ex_pc_d    = ifid_pc_q;
      ex_a_d     = opnd_a;
      ex_b_d     = opnd_b;
      ex_imm_d   = dec_imm;
      ex_wa_d    = dec_wa;
      ex_ctrl_d  = dec_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      ex_imm_q     <= '0;
      ex_wa_q      <= '0;
      ex_ctrl_q    <= '0;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_a_q       <= ex_a_d;
      ex_b_q       <= ex_b_d;
      ex_imm_q     <= ex_imm_d;
      ex_wa_q      <= ex_wa_d;
      ex_ctrl_q    <= ex_ctrl_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_pc       = ex_pc_q;
  assign bus.ex_a        = ex_a_q;
  assign bus.ex_b        = ex_b_q;
  assign bus.ex_imm      = ex_imm_q;
  assign bus.ex_wa       = ex_wa_q;
  assign bus.ex_regwrite = ex_ctrl_q.regwrite;
  assign bus.ex_memread  = ex_ctrl_q.memread;
  assign bus.ex_memwrite = ex_ctrl_q.memwrite;
  assign bus.ex_alusrc   = ex_ctrl_q.alusrc;
  assign bus.ex_cbz      = ex_ctrl_q.cbz;
  assign bus.ex_b_uncond = ex_ctrl_q.b_uncond;
  assign bus.ex_aluctl   = ex_ctrl_q.aluctl;
  assign bus.ex_illegal  = ex_ctrl_q.illegal;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- LEGv8 decode stage, sitting between fetch and execute; 64-bit datapath, 32 registers, register 31 is XZR.
- Holds the IF/ID pipeline register and drives the register-file read addresses.
- Captures the asynchronous read data, with a writeback bypass, plus decoded control into the ID/EX pipeline register.
- Detects load-use hazards (stall) and applies branch flushes coming from EX.

Parameters:
- DW, 64, datapath width.
- AW, 5, register address width.

Ports:
- clk in 1: clock; all state updates on posedge.
- reset in 1: synchronous, active-high.
- if_valid in 1: fetch presents an instruction.
- if_instr in 32: fetched instruction.
- if_pc in DW: PC of if_instr.
- stall out 1: fetch must hold PC and instruction this cycle.
- flush in 1: branch taken in EX; kill younger instructions.
- ra1 out AW: register-file read address 1 (Rn).
- ra2 out AW: read address 2 (Rm for R-type, Rt for STUR/CBZ).
- rd1 in DW: register-file read data 1 (asynchronous).
- rd2 in DW: register-file read data 2 (asynchronous).
- wb_we in 1: writeback write enable (same cycle as the register-file write).
- wb_wa in AW: writeback address.
- wb_wd in DW: writeback data.
- ex_valid out 1: ID/EX holds a live instruction.
- ex_pc out DW: PC.
- ex_a out DW: operand A.
- ex_b out DW: operand B (register).
- ex_imm out DW: sign-extended immediate.
- ex_wa out AW: destination register.
- ex_regwrite out 1: control bit.
- ex_memread out 1: control bit.
- ex_memwrite out 1: control bit.
- ex_alusrc out 1: control bit.
- ex_cbz out 1: control bit.
- ex_b_uncond out 1: control bit.
- ex_aluctl out 4: ALU operation code.
- ex_illegal out 1: instruction did not decode.

Behaviour:
- Reset: IF/ID valid=0, instr=0, pc=0. Every ex_* output=0. stall=0.
- Latency: an instruction captured in IF/ID at edge N appears on ex_* after edge N+1.
- IF/ID update priority (highest first):
  - reset → clear.
  - flush → valid=0.
  - stall → hold.
  - else → load {if_valid, if_instr, if_pc}.
- ID/EX update priority (highest first):
  - reset → clear.
  - flush or stall or !IF/ID valid → bubble (all fields 0, ex_valid=0).
  - else → load decoded fields.
- flush and stall in the same cycle: flush wins, and stall is forced to 0.
- Decode keys on instr[31:21], with CBZ on [31:24] and B on [31:26]:
  - ADD 10001011000: aluctl 0010, regwrite=1.
  - SUB 11001011000: aluctl 0110, regwrite=1.
  - AND 10001010000: aluctl 0000, regwrite=1.
  - ORR 10101010000: aluctl 0001, regwrite=1.
  - LDUR 11111000010: ra1=Rn, wa=Rt, imm=sext(instr[20:12]), alusrc=1, memread=1, regwrite=1, aluctl 0010.
  - STUR 11111000000: ra1=Rn, ra2=Rt, imm=sext(instr[20:12]), alusrc=1, memwrite=1, aluctl 0010.
  - CBZ 10110100: ra2=Rt, imm=sext(instr[23:5]), cbz=1, aluctl 0111.
  - B 000101: imm=sext(instr[25:0]), b_uncond=1.
  - R-type field mapping: ra1=Rn[9:5], ra2=Rm[20:16], wa=Rd[4:0].
  - Any other opcode: all control 0, ex_illegal=1, ex_valid=1.
- ra1/ra2 are combinational from the IF/ID instruction. Unused fields still drive their raw instruction bits.
- Operand capture, per port: if the address is 31 → 0. Else if wb_we && wb_wa==addr → wb_wd. Else → rd.
- Load-use stall: stall=1 when all of these hold:
  - ex_valid && ex_memread && ex_wa≠31;
  - ex_wa equals a source the IF/ID instruction actually uses (ra1 for R/LDUR/STUR; ra2 for R/STUR/CBZ);
  - IF/ID valid && !flush.
- The stall lasts exactly one cycle, because the bubble clears ex_memread.
- Destination 31: regwrite stays as decoded. Downstream logic and the register file discard the write.

Decomposition:
- Package legv8_pkg holds:
  - opcode localparams;
  - XZR constant 5'd31;
  - aluctl constants;
  - packed struct ctrl_t {regwrite, memread, memwrite, alusrc, cbz, b_uncond, illegal, aluctl}.
- Sub-module legv8_decoder (combinational): takes instr and produces ctrl_t, ra1, ra2, wa, imm, uses_ra1, uses_ra2.
- id_stage owns the pipeline registers, bypass, hazard and flush logic.

Test Plan:
- ADD X3,X1,X2 (0x8B020023), rd1=1, rd2=2 → ra1=1, ra2=2. Next edge: ex_a=1, ex_b=2, ex_wa=3, aluctl=0010, regwrite=1.
- LDUR X5,[X1,#-8] then ADD X6,X5,X2 back-to-back:
  - stall=1 for exactly one cycle, and a bubble (ex_valid=0) is inserted;
  - the ADD enters ID/EX next cycle;
  - imm = 0xFFFF_FFFF_FFFF_FFF8.
- ADD X1,X31,X31 with rd1=rd2=0xDEAD → ex_a=ex_b=0. A LDUR X31 followed by a consumer of X31 → no stall.
- wb_we=1, wb_wa=2, wb_wd=0x1234 while ID holds ADD X3,X2,X2 and rd=2 → ex_a=ex_b=0x1234.
- flush asserted together with a load-use stall → IF/ID valid=0, ex_valid=0, stall=0. The next fetched instruction is captured normally.
- Reset asserted mid-stream while an instruction sits in ID/EX → every ex_* output is 0 after the edge. Opcode 0xFFFFFFFF → ex_illegal=1, ex_valid=1, all other control bits 0.
